predicate_register_file_param: RTL

- Parametrised next-generation per-warp predicate register file for the SIMT core: LANES x NREGS x NWARPS 1-bit predicates, NRPORTS read ports, one write port.
- Adds over the fixed 8-lane/2-port block:
  - independent read and write warp selects;
  - registered reads with write-first bypass;
  - per-port valid;
  - a multi-cycle warp-clear sequencer used at warp launch.
- Sits between decode/issue (reads) and writeback (writes), beside the general register file.

---
 rtl/predicate_rf_pkg.sv | 22 ++
 rtl/predicate_clear_seq.sv | 71 +++++++
 rtl/predicate_register_file_param.sv | 91 +++++++++
 3 files changed

// File: rtl/predicate_rf_pkg.sv
// Shared constants, clear-sequencer state type and port/lane packing helper
// for the parametrised predicate register file.
package predicate_rf_pkg;

  localparam int unsigned DefLanes   = 8;
  localparam int unsigned DefNregs   = 32;
  localparam int unsigned DefNwarps  = 16;
  localparam int unsigned DefNrports = 2;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clr_state_e;

  // Bit position of (port, lane) in a port-major packed lane vector.
  function automatic int unsigned lane_idx(input int unsigned port, input int unsigned lane,
                                           input int unsigned lanes);
    return port * lanes + lane;
  endfunction

endpackage

// File: rtl/predicate_clear_seq.sv
// Warp-clear sequencer: walks every register of the latched warp, one per cycle,
// and pulses clear_done once the last register has been zeroed.
module predicate_clear_seq
  import predicate_rf_pkg::*;
#(
  parameter int unsigned NREGS  = DefNregs,
  parameter int unsigned NWARPS = DefNwarps,
  localparam int unsigned AW    = $clog2(NREGS),
  localparam int unsigned WW    = $clog2(NWARPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  input  logic [WW-1:0] clear_warp,
  output logic          clr_en,
  output logic [WW-1:0] clr_warp,
  output logic [AW-1:0] clr_reg,
  output logic          clear_busy,
  output logic          clear_done
);

  localparam logic [AW-1:0] LastReg = AW'(NREGS - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] cw_q, cw_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cw_q    <= cw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cw_d       = cw_q;
    clr_en     = 1'b0;
    clear_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          cw_d    = clear_warp;
          ptr_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        clr_en = 1'b1;
        if (ptr_q == LastReg) state_d = StDone;
        else                  ptr_d   = ptr_q + AW'(1);
      end
      StDone: begin
        clear_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr_warp   = cw_q;
  assign clr_reg    = ptr_q;
  assign clear_busy = (state_q != StIdle);

endmodule

// File: rtl/predicate_register_file_param.sv
// Per-warp predicate register file: LANES x NREGS x NWARPS bits, NRPORTS registered
// write-first read ports, one lane-masked write port and a warp-clear sequencer.
module predicate_register_file_param
  import predicate_rf_pkg::*;
#(
  parameter int unsigned LANES   = DefLanes,
  parameter int unsigned NREGS   = DefNregs,
  parameter int unsigned NWARPS  = DefNwarps,
  parameter int unsigned NRPORTS = DefNrports,
  localparam int unsigned AW     = $clog2(NREGS),
  localparam int unsigned WW     = $clog2(NWARPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NRPORTS*LANES-1:0]   read_en,
  input  logic [NRPORTS*AW-1:0]      raddr,
  input  logic [WW-1:0]              rd_warp,
  input  logic [LANES-1:0]           write_en,
  input  logic [AW-1:0]              waddr,
  input  logic [WW-1:0]              wr_warp,
  input  logic [LANES-1:0]           wdata,
  output logic [NRPORTS*LANES-1:0]   rdata,
  output logic [NRPORTS-1:0]         rdata_valid,
  input  logic                       clear_req,
  input  logic [WW-1:0]              clear_warp,
  output logic                       clear_busy,
  output logic                       clear_done
);

  logic [LANES-1:0] mem_q [NWARPS][NREGS];
  logic [LANES-1:0] mem_d [NWARPS][NREGS];

  logic [NRPORTS*LANES-1:0] rdata_q, rdata_d;
  logic [NRPORTS-1:0]       valid_q, valid_d;

  logic          clr_en;
  logic [WW-1:0] clr_warp;
  logic [AW-1:0] clr_reg;

  predicate_clear_seq #(
    .NREGS  (NREGS),
    .NWARPS (NWARPS)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .clear_warp (clear_warp),
    .clr_en     (clr_en),
    .clr_warp   (clr_warp),
    .clr_reg    (clr_reg),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  // Clear first, then the write, so enabled write lanes win a collision.
  // Reads then look at the merged next state, giving write-first behaviour.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = '0;
    valid_d = '0;
    if (clr_en && (32'(clr_warp) < NWARPS)) begin
      mem_d[clr_warp][clr_reg] = '0;
    end
    if ((32'(wr_warp) < NWARPS) && (32'(waddr) < NREGS)) begin
      mem_d[wr_warp][waddr] = (mem_d[wr_warp][waddr] & ~write_en) | (wdata & write_en);
    end
    for (int unsigned p = 0; p < NRPORTS; p++) begin
      valid_d[p] = |read_en[lane_idx(p, 0, LANES) +: LANES];
      if ((32'(rd_warp) < NWARPS) && (32'(raddr[p*AW +: AW]) < NREGS)) begin
        rdata_d[lane_idx(p, 0, LANES) +: LANES] =
          read_en[lane_idx(p, 0, LANES) +: LANES] & mem_d[rd_warp][raddr[p*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;

endmodule
